// File: rtl/ifu_prefetch.sv
`default_nettype none
// ============================================================================
// Module   : ifu_prefetch
// Brief    : Credit-limited instruction prefetcher with in-order response FIFO,
//            redirect flush with stale-response draining, and fault halt.
// Revision : 1.0
// ============================================================================
module ifu_prefetch #(
    parameter int                ADDR_W   = 32,
    parameter int                INS_W    = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic              i_clk,
    input  logic              i_rst,
    output logic              o_req_valid,
    input  logic              i_req_ready,
    output logic [ADDR_W-1:0] o_req_addr,
    input  logic              i_rsp_valid,
    input  logic [INS_W-1:0]  i_rsp_data,
    input  logic              i_rsp_err,
    input  logic              i_redirect,
    input  logic [ADDR_W-1:0] i_redirect_pc,
    output logic              o_ins_valid,
    input  logic              i_ins_ready,
    output logic [INS_W-1:0]  o_ins,
    output logic [ADDR_W-1:0] o_ins_pc,
    output logic              o_ins_err
);

    localparam int                PW      = $clog2(DEPTH);
    localparam int                CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]     C_ONE   = CW'(1);
    localparam logic [CW-1:0]     C_ZERO  = '0;
    localparam logic [PW-1:0]     C_PONE  = PW'(1);
    localparam logic [CW:0]       C_DEPTH = (CW+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] C_STEP  = ADDR_W'(INS_W / 8);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_fpc;
    logic [CW-1:0]       r_outst;
    logic [CW-1:0]       r_stale;
    logic [CW-1:0]       r_cnt;
    logic [PW-1:0]       r_wr;
    logic [PW-1:0]       r_rd;
    logic [PW-1:0]       r_awr;
    logic [PW-1:0]       r_ard;

    logic [ADDR_W-1:0]   r_amem [DEPTH];
    logic [INS_W-1:0]    r_dmem [DEPTH];
    logic [ADDR_W-1:0]   r_pmem [DEPTH];
    logic                r_emem [DEPTH];

    logic [CW:0]         w_used;
    logic                w_req_valid;
    logic                w_acc;
    logic                w_rsp;
    logic                w_redir;
    logic                w_push;
    logic                w_pop;
    logic                w_nonempty;
    logic [CW-1:0]       w_outst_nxt;

    // Buffered plus in-flight never exceeds DEPTH, so a push always has room.
    assign w_used      = {1'b0, r_cnt} + {1'b0, r_outst};
    assign w_req_valid = (r_state == S_RUN) && (w_used < C_DEPTH);
    assign w_acc       = w_req_valid && i_req_ready;
    assign w_rsp       = i_rsp_valid && (r_outst != C_ZERO);
    assign w_redir     = i_redirect && (r_state != S_BOOT);
    assign w_push      = w_rsp && !w_redir && ((r_state == S_RUN) || (r_state == S_HALT));
    assign w_nonempty  = (r_cnt != C_ZERO);
    assign w_pop       = w_nonempty && i_ins_ready;
    assign w_outst_nxt = r_outst + (w_acc ? C_ONE : C_ZERO) - (w_rsp ? C_ONE : C_ZERO);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_BOOT;
            r_fpc   <= RESET_PC;
            r_outst <= C_ZERO;
            r_stale <= C_ZERO;
            r_cnt   <= C_ZERO;
            r_wr    <= '0;
            r_rd    <= '0;
            r_awr   <= '0;
            r_ard   <= '0;
        end else begin
            r_outst <= w_outst_nxt;
            if (w_acc) begin
                r_fpc <= r_fpc + C_STEP;
                r_awr <= r_awr + C_PONE;
            end
            if (w_rsp && (r_state != S_DRAIN)) begin
                r_ard <= r_ard + C_PONE;
            end
            if (w_push) begin
                r_wr <= r_wr + C_PONE;
            end
            if (w_pop) begin
                r_rd <= r_rd + C_PONE;
            end
            if (w_push && !w_pop) begin
                r_cnt <= r_cnt + C_ONE;
            end else if (!w_push && w_pop) begin
                r_cnt <= r_cnt - C_ONE;
            end

            case (r_state)
                S_BOOT:  r_state <= S_RUN;
                S_RUN:   if (w_push && i_rsp_err) r_state <= S_HALT;
                S_DRAIN: begin
                    if (w_rsp) begin
                        r_stale <= r_stale - C_ONE;
                        if (r_stale == C_ONE) r_state <= S_RUN;
                    end
                end
                S_HALT:  r_state <= S_HALT;
                default: r_state <= S_BOOT;
            endcase

            // Flush overrides everything above; in-flight requests become stale.
            if (w_redir) begin
                r_fpc   <= i_redirect_pc;
                r_cnt   <= C_ZERO;
                r_wr    <= '0;
                r_rd    <= '0;
                r_awr   <= '0;
                r_ard   <= '0;
                r_stale <= w_outst_nxt;
                r_state <= (w_outst_nxt != C_ZERO) ? S_DRAIN : S_RUN;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_acc) begin
            r_amem[r_awr] <= r_fpc;
        end
        if (w_push) begin
            r_dmem[r_wr] <= i_rsp_data;
            r_pmem[r_wr] <= r_amem[r_ard];
            r_emem[r_wr] <= i_rsp_err;
        end
    end

    assign o_req_valid = w_req_valid;
    assign o_req_addr  = r_fpc;
    assign o_ins_valid = w_nonempty;
    assign o_ins       = w_nonempty ? r_dmem[r_rd] : '0;
    assign o_ins_pc    = w_nonempty ? r_pmem[r_rd] : '0;
    assign o_ins_err   = w_nonempty ? r_emem[r_rd] : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_ifu_prefetch.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_ifu_prefetch
// Brief    : Directed self-checking bench for ifu_prefetch.
// Revision : 1.0
// ============================================================================
module tb_ifu_prefetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid;
    logic        req_ready = 1'b1;
    logic [31:0] req_addr;
    logic        rsp_valid = 1'b0;
    logic [31:0] rsp_data = '0;
    logic        rsp_err = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        ins_valid;
    logic        ins_ready = 1'b1;
    logic [31:0] ins;
    logic [31:0] ins_pc;
    logic        ins_err;

    always #5 clk = ~clk;

    ifu_prefetch #(
        .ADDR_W   (32),
        .INS_W    (32),
        .DEPTH    (4),
        .RESET_PC (32'h8000_0000)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .o_req_valid   (req_valid),
        .i_req_ready   (req_ready),
        .o_req_addr    (req_addr),
        .i_rsp_valid   (rsp_valid),
        .i_rsp_data    (rsp_data),
        .i_rsp_err     (rsp_err),
        .i_redirect    (redirect),
        .i_redirect_pc (redirect_pc),
        .o_ins_valid   (ins_valid),
        .i_ins_ready   (ins_ready),
        .o_ins         (ins),
        .o_ins_pc      (ins_pc),
        .o_ins_err     (ins_err)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_unstable = 0;
    logic [31:0] mq[$];
    logic [31:0] acc_log[$];
    logic [31:0] del_ins[$];
    logic [31:0] del_pc[$];
    logic        del_err[$];
    bit          mem_en = 1'b1;
    bit          err_en = 1'b0;
    logic [31:0] err_addr = 32'hFFFF_FFFF;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: log handshakes, then act as an in-order 1-cycle memory.
    task automatic tick();
        bit          acc;
        bit          hold;
        logic [31:0] a;
        logic [31:0] prev;
        acc  = req_valid && req_ready;
        a    = req_addr;
        hold = ins_valid && !ins_ready;
        prev = ins;
        if (ins_valid && ins_ready) begin
            del_ins.push_back(ins);
            del_pc.push_back(ins_pc);
            del_err.push_back(ins_err);
        end
        @(posedge clk);
        #1;
        if (acc) begin
            mq.push_back(a);
            acc_log.push_back(a);
        end
        if (hold && ins_valid && !redirect && !rst && (ins !== prev)) n_unstable++;
        if (mem_en && (mq.size() > 0)) begin
            rsp_valid = 1'b1;
            rsp_data  = mq.pop_front();
            rsp_err   = err_en && (rsp_data == err_addr);
        end else begin
            rsp_valid = 1'b0;
            rsp_data  = '0;
            rsp_err   = 1'b0;
        end
    endtask

    task automatic clear_logs();
        acc_log.delete();
        del_ins.delete();
        del_pc.delete();
        del_err.delete();
    endtask

    task automatic reset_values(input string tag);
        check({tag, "_req_valid"}, 64'(req_valid), 64'd0);
        check({tag, "_ins_valid"}, 64'(ins_valid), 64'd0);
        check({tag, "_ins"},       64'(ins),       64'd0);
        check({tag, "_ins_pc"},    64'(ins_pc),    64'd0);
        check({tag, "_ins_err"},   64'(ins_err),   64'd0);
        check({tag, "_req_addr"},  64'(req_addr),  64'h8000_0000);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        redirect = 1'b0;
        mq.delete();
        repeat (2) tick();
        clear_logs();
        rst = 1'b0;
    endtask

    initial begin
        int cnt;

        // Reset state
        rst = 1'b1;
        repeat (2) tick();
        reset_values("rst");
        rst = 1'b0;
        check("boot_no_req", 64'(req_valid), 64'd0);

        // Streaming: one instruction per cycle, pc equals data
        repeat (14) tick();
        check("stream_count", 64'(del_ins.size()), 64'd11);
        for (int k = 0; k < 8; k++) begin
            check("stream_ins", 64'(del_ins[k]), 64'(32'h8000_0000 + 32'(4 * k)));
            check("stream_pc",  64'(del_pc[k]),  64'(32'h8000_0000 + 32'(4 * k)));
        end

        // Backpressure from reset: exactly DEPTH requests, head held stable
        ins_ready = 1'b0;
        do_reset();
        repeat (22) tick();
        check("bp_reqs",      64'(acc_log.size()), 64'd4);
        check("bp_ins_valid", 64'(ins_valid),      64'd1);
        check("bp_ins",       64'(ins),            64'h8000_0000);
        check("bp_req_valid", 64'(req_valid),      64'd0);
        ins_ready = 1'b1;
        repeat (12) tick();
        for (int k = 0; k < 8; k++) begin
            check("bp_pc", 64'(del_pc[k]), 64'(32'h8000_0000 + 32'(4 * k)));
        end
        check("bp_stable", 64'(n_unstable), 64'd0);

        // Redirect with three outstanding requests
        mem_en = 1'b0;
        do_reset();
        repeat (4) tick();
        check("rd_outstanding", 64'(acc_log.size()), 64'd3);
        req_ready   = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h8000_1000;
        tick();
        redirect  = 1'b0;
        req_ready = 1'b1;
        mem_en    = 1'b1;
        clear_logs();
        check("rd_ins_flushed", 64'(ins_valid), 64'd0);
        cnt = (req_valid) ? 1 : 0;
        repeat (3) begin
            tick();
            if (req_valid) cnt++;
        end
        check("rd_drain_no_req", 64'(cnt),            64'd0);
        check("rd_drain_no_acc", 64'(acc_log.size()), 64'd0);
        tick();
        check("rd_resume_valid", 64'(req_valid), 64'd1);
        check("rd_resume_addr",  64'(req_addr),  64'h8000_1000);
        repeat (4) tick();
        check("rd_first_pc", 64'(del_pc[0]), 64'h8000_1000);

        // Access fault at 8000_0008
        do_reset();
        err_en   = 1'b1;
        err_addr = 32'h8000_0008;
        repeat (16) tick();
        check("flt_reqs",      64'(acc_log.size()), 64'd4);
        check("flt_count",     64'(del_pc.size()),  64'd4);
        check("flt_pc2",       64'(del_pc[2]),      64'h8000_0008);
        check("flt_err2",      64'(del_err[2]),     64'd1);
        check("flt_err0",      64'(del_err[0]),     64'd0);
        check("flt_pc3",       64'(del_pc[3]),      64'h8000_000C);
        check("flt_err3",      64'(del_err[3]),     64'd0);
        check("flt_req_valid", 64'(req_valid),      64'd0);
        err_en      = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h8000_2000;
        tick();
        redirect = 1'b0;
        clear_logs();
        repeat (6) tick();
        check("flt_resume_acc", 64'(acc_log[0]), 64'h8000_2000);
        check("flt_resume_pc",  64'(del_pc[0]),  64'h8000_2000);
        check("flt_resume_err", 64'(del_err[0]), 64'd0);

        // Address wrap, redirected while streaming
        req_ready   = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect  = 1'b0;
        req_ready = 1'b1;
        clear_logs();
        repeat (10) tick();
        check("wrap_acc0", 64'(acc_log[0]), 64'hFFFF_FFFC);
        check("wrap_acc1", 64'(acc_log[1]), 64'h0000_0000);
        check("wrap_pc0",  64'(del_pc[0]),  64'hFFFF_FFFC);
        check("wrap_pc1",  64'(del_pc[1]),  64'h0000_0000);

        // Asynchronous reset with two requests outstanding
        mem_en = 1'b0;
        do_reset();
        repeat (3) tick();
        check("mr_outstanding", 64'(acc_log.size()), 64'd2);
        rst = 1'b1;
        #1;
        reset_values("mr");
        mem_en = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        clear_logs();
        repeat (6) tick();
        check("mr_first_acc", 64'(acc_log[0]), 64'h8000_0000);
        check("mr_first_pc",  64'(del_pc[0]),  64'h8000_0000);
        check("mr_first_ins", 64'(del_ins[0]), 64'h8000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
